data_ram_resp: RTL and testbench

Responder for the core's data-memory port. It serves load/store requests issued by the MEM stage: word-addressed on-chip SRAM with byte-lane writes, plus a small memory-mapped timer block (counter, compare, sticky match flag, interrupt). Reads are combinational so load data returns in the same cycle the MEM stage presents the address. Writes commit on the rising clock edge.

---
 rtl/data_ram_resp.sv | 147 ++++++++++++++
 tb/tb_data_ram_resp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM stage: word-addressed SRAM with byte-lane
// stores plus a memory-mapped timer (COUNT / COMPARE / STATUS) raising irq.
module data_ram_resp #(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        irq
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [1:0] REG_COUNT    = 2'd0;
   localparam logic [1:0] REG_COMPARE  = 2'd1;
   localparam logic [1:0] REG_STATUS   = 2'd2;

   logic [31:0]       mem [DEPTH];

   logic              mmio_hit;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        reg_off;
   logic              sram_wr;
   logic              mmio_wr;
   logic              wr_count;
   logic              wr_compare;
   logic              wr_status;

   logic [31:0]       count;
   logic [31:0]       compare;
   logic              en;
   logic              ie;
   logic              match;

   logic [31:0]       count_next;
   logic [31:0]       compare_next;
   logic              en_next;
   logic              ie_next;
   logic              match_set;
   logic              match_clr;
   logic              match_next;
   logic [31:0]       mmio_rdata;

   // The two byte-offset bits never participate in word addressing.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^addr[1:0];

   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return res;
   endfunction

   assign mmio_hit   = (addr[31:4] == MMIO_BASE[31:4]);
   assign idx        = addr[ADDR_W+1:2];
   assign reg_off    = addr[3:2];
   assign sram_wr    = ce & we & ~mmio_hit;
   assign mmio_wr    = ce & we & mmio_hit;
   assign wr_count   = mmio_wr & (reg_off == REG_COUNT);
   assign wr_compare = mmio_wr & (reg_off == REG_COMPARE);
   assign wr_status  = mmio_wr & (reg_off == REG_STATUS);

   // SRAM is deliberately not reset; loads see the old word until the edge.
   always_ff @(posedge clk) begin
      if (sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
               mem[idx][8*i +: 8] <= data_i[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      count_next = count;
      if (wr_count) begin
         count_next = lane_merge(count, data_i, sel);
      end else if (en) begin
         count_next = count + 32'd1;
      end

      compare_next = compare;
      if (wr_compare) begin
         compare_next = lane_merge(compare, data_i, sel);
      end

      en_next   = en;
      ie_next   = ie;
      match_clr = 1'b0;
      if (wr_status && sel[0]) begin
         en_next   = data_i[1];
         ie_next   = data_i[2];
         match_clr = data_i[0];
      end

      // A match detected on this edge wins over a simultaneous write-1-to-clear.
      match_set  = en & (count == compare);
      match_next = match_set | (match & ~match_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= 32'd0;
         compare <= 32'hFFFF_FFFF;
         en      <= 1'b0;
         ie      <= 1'b0;
         match   <= 1'b0;
         irq     <= 1'b0;
      end else begin
         count   <= count_next;
         compare <= compare_next;
         en      <= en_next;
         ie      <= ie_next;
         match   <= match_next;
         irq     <= match_next & ie_next;
      end
   end

   always_comb begin
      mmio_rdata = 32'd0;
      case (reg_off)
         REG_COUNT:   mmio_rdata = count;
         REG_COMPARE: mmio_rdata = compare;
         REG_STATUS:  mmio_rdata = {29'd0, ie, en, match};
         default:     mmio_rdata = 32'd0;
      endcase

      data_o = 32'd0;
      if (rst && ce && !we) begin
         data_o = mmio_hit ? mmio_rdata : mem[idx];
      end
   end

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: directed scenarios followed by random
// traffic, all compared against a behavioural model of memory and timer.
module tb_data_ram_resp;

   localparam int          ADDR_W    = 12;
   localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
   localparam logic [31:0] A_COUNT   = MMIO_BASE + 32'h0;
   localparam logic [31:0] A_COMPARE = MMIO_BASE + 32'h4;
   localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'h8;
   localparam logic [31:0] A_RSVD    = MMIO_BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [3:0]  sel = 4'd0;
   logic [31:0] data_i = 32'd0;
   logic [31:0] data_o;
   logic        irq;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_mem [int];
   logic [31:0] m_count;
   logic [31:0] m_compare;
   bit          m_en;
   bit          m_ie;
   bit          m_match;
   bit          m_irq;

   data_ram_resp #(.ADDR_W(ADDR_W), .MMIO_BASE(MMIO_BASE)) dut (
      .clk    (clk),
      .rst    (rst),
      .ce     (ce),
      .we     (we),
      .addr   (addr),
      .sel    (sel),
      .data_i (data_i),
      .data_o (data_o),
      .irq    (irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mergeLanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

   function automatic bit isMmio(input logic [31:0] a);
      return a[31:4] == MMIO_BASE[31:4];
   endfunction

   function automatic int wordIndex(input logic [31:0] a);
      return int'(a[ADDR_W+1:2]);
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      int k;
      if (isMmio(a)) begin
         case (a[3:2])
            2'd0:    return m_count;
            2'd1:    return m_compare;
            2'd2:    return {29'd0, m_ie, m_en, m_match};
            default: return 32'd0;
         endcase
      end
      k = wordIndex(a);
      if (m_mem.exists(k)) return m_mem[k];
      return 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] expectedData();
      if (rst && ce && !we) return modelRead(addr);
      return 32'd0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_count   = 32'd0;
      m_compare = 32'hFFFF_FFFF;
      m_en      = 1'b0;
      m_ie      = 1'b0;
      m_match   = 1'b0;
      m_irq     = 1'b0;
   endtask

   // What one rising edge does to memory and timer, given the request on the bus.
   task automatic modelEdge();
      bit          wr;
      bit          hit;
      bit          hit_match;
      bit          clear_req;
      logic [31:0] new_count;
      logic [31:0] new_compare;
      logic [31:0] old_word;
      int          k;
      wr        = ce && we;
      hit       = isMmio(addr);
      hit_match = m_en && (m_count == m_compare);
      clear_req = 1'b0;
      new_count   = m_en ? m_count + 32'd1 : m_count;
      new_compare = m_compare;
      if (wr && hit && addr[3:2] == 2'd0) new_count = mergeLanes(m_count, data_i, sel);
      if (wr && hit && addr[3:2] == 2'd1) new_compare = mergeLanes(m_compare, data_i, sel);
      if (wr && hit && addr[3:2] == 2'd2 && sel[0]) begin
         m_en      = data_i[1];
         m_ie      = data_i[2];
         clear_req = data_i[0];
      end
      if (wr && !hit) begin
         k = wordIndex(addr);
         old_word = m_mem.exists(k) ? m_mem[k] : 32'hxxxx_xxxx;
         m_mem[k] = mergeLanes(old_word, data_i, sel);
      end
      m_match   = hit_match || (m_match && !clear_req);
      m_count   = new_count;
      m_compare = new_compare;
      m_irq     = m_match && m_ie;
   endtask

   // One bus cycle: drive at negedge, check load data, clock it, check irq.
   task automatic applyStimulus(input bit c, input bit w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d,
                                input string tag, input bit use_lit = 1'b0,
                                input logic [31:0] lit = 32'd0);
      @(negedge clk);
      ce = c; we = w; addr = a; sel = s; data_i = d;
      #1;
      checkOutput({tag, "_data"}, data_o, expectedData());
      if (use_lit) checkOutput({tag, "_lit"}, data_o, lit);
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
   endtask

   task automatic loadExpect(input logic [31:0] a, input logic [31:0] lit, input string tag);
      applyStimulus(1'b1, 1'b0, a, 4'hF, 32'd0, tag, 1'b1, lit);
   endtask

   task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input string tag);
      applyStimulus(1'b1, 1'b1, a, s, d, tag);
   endtask

   // Reset is asserted between edges and must take effect without a clock.
   task automatic doReset(input string tag);
      @(negedge clk);
      ce = 1'b1; we = 1'b0; addr = A_COUNT; sel = 4'hF; data_i = 32'd0;
      #2;
      rst = 1'b0;
      modelReset();
      #1;
      checkOutput({tag, "_data"}, data_o, 32'd0);
      checkOutput({tag, "_irq"}, {31'd0, irq}, 32'd0);
      @(negedge clk);
      ce = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   initial begin
      int          pool [8];
      logic [31:0] a;
      logic [31:0] hi;
      logic [31:0] d;
      logic [3:0]  s;
      int          choice;

      modelReset();
      $display("[TB] reset and basic SRAM access");
      doReset("por");
      loadExpect(A_COUNT, 32'd0, "rst_count");
      loadExpect(A_COMPARE, 32'hFFFF_FFFF, "rst_compare");
      loadExpect(A_STATUS, 32'd0, "rst_status");

      store(32'h40, 4'hF, 32'hDEAD_BEEF, "st40");
      loadExpect(32'h40, 32'hDEAD_BEEF, "ld40");
      applyStimulus(1'b0, 1'b0, 32'h40, 4'hF, 32'd0, "ce0", 1'b1, 32'd0);

      $display("[TB] byte lanes and aliasing");
      store(32'h40, 4'b0100, 32'h00AA_0000, "st_lane2");
      loadExpect(32'h40, 32'hDEAA_BEEF, "ld_lane2");
      store(32'h40, 4'b0000, 32'h1234_5678, "st_sel0");
      loadExpect(32'h40, 32'hDEAA_BEEF, "ld_sel0");
      loadExpect(32'h40 + (32'd4 << ADDR_W), 32'hDEAA_BEEF, "ld_alias");
      store(A_RSVD, 4'hF, 32'hFFFF_FFFF, "st_rsvd");
      loadExpect(A_RSVD, 32'd0, "ld_rsvd");

      $display("[TB] timer count and match");
      store(A_COMPARE, 4'hF, 32'd5, "wr_cmp5");
      store(A_STATUS, 4'hF, 32'h6, "wr_en_ie");
      for (int k = 0; k < 6; k++) loadExpect(A_COUNT, 32'(k), "cnt_seq");
      loadExpect(A_STATUS, 32'h7, "match_set");
      checkOutput("irq_after_match", {31'd0, irq}, 32'd1);
      store(A_STATUS, 4'hF, 32'h7, "w1c");
      checkOutput("irq_after_w1c", {31'd0, irq}, 32'd0);
      loadExpect(A_STATUS, 32'h6, "status_cleared");
      loadExpect(A_COUNT, 32'd9, "cnt_continues");

      $display("[TB] set-over-clear and write-over-increment priority");
      store(A_COMPARE, 4'hF, 32'h20, "wr_cmp20");
      store(A_COUNT, 4'hF, 32'h20, "wr_cnt20");
      store(A_STATUS, 4'hF, 32'h7, "w1c_vs_set");
      loadExpect(A_STATUS, 32'h7, "set_wins");
      store(A_COUNT, 4'hF, 32'h10, "wr_cnt10");
      loadExpect(A_COUNT, 32'h10, "wr_beats_inc");

      $display("[TB] counter wrap");
      store(A_STATUS, 4'hF, 32'h7, "w1c2");
      store(A_COMPARE, 4'hF, 32'd0, "wr_cmp0");
      store(A_COUNT, 4'hF, 32'hFFFF_FFFF, "wr_cnt_max");
      loadExpect(A_COUNT, 32'hFFFF_FFFF, "cnt_max");
      loadExpect(A_COUNT, 32'd0, "cnt_wrap");
      loadExpect(A_STATUS, 32'h7, "match_at_0");
      checkOutput("irq_wrap", {31'd0, irq}, 32'd1);

      $display("[TB] asynchronous reset mid-run");
      doReset("mid_rst");
      loadExpect(A_COUNT, 32'd0, "post_rst_count");
      loadExpect(A_STATUS, 32'd0, "post_rst_status");
      loadExpect(32'h40, 32'hDEAA_BEEF, "sram_retained");

      $display("[TB] random traffic");
      for (int i = 0; i < 8; i++) begin
         pool[i] = int'($urandom_range(0, (1 << ADDR_W) - 1));
         store(32'(pool[i]) << 2, 4'hF, $urandom, "rnd_init");
      end
      store(A_STATUS, 4'hF, 32'h6, "rnd_en");
      for (int i = 0; i < 300; i++) begin
         choice = int'($urandom_range(0, 7));
         hi = $urandom_range(0, 16'h3FFF);
         a = (hi << 14) | (32'(pool[$urandom_range(0, 7)]) << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         case (choice)
            0, 1: store(a, s, d, "rnd_st");
            2, 3: applyStimulus(1'b1, 1'b0, a, s, 32'd0, "rnd_ld");
            4: begin
               a = MMIO_BASE | (32'($urandom_range(0, 3)) << 2);
               if (a[3:2] == 2'd1) d = m_count + 32'($urandom_range(1, 6));
               if (a[3:2] == 2'd2) d = {29'd0, 3'($urandom_range(0, 7)) | 3'b010};
               store(a, s, d, "rnd_mmio_wr");
            end
            5, 6: applyStimulus(1'b1, 1'b0, MMIO_BASE | (32'($urandom_range(0, 3)) << 2),
                                s, 32'd0, "rnd_mmio_rd");
            default: applyStimulus(1'b0, 1'($urandom_range(0, 1)), a, s, d, "rnd_idle");
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
